// File: rtl/streamif_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// streamif_pkg: shared stream widths and helper functions
// Revision: 1.0
// ------------------------------------------------------------------
package streamif_pkg;

  localparam int DEF_TDATA_WIDTH   = 32;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_PKT_LEN_WIDTH = 16;
  localparam int MAX_STRB_WIDTH    = 128;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Caller narrows the result to data_width/8 bits.
  function automatic logic [MAX_STRB_WIDTH-1:0] strb_ones(input int data_width);
    logic [MAX_STRB_WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      if (i < data_width / 8) result[i] = 1'b1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// stream_sync_fifo: single-clock FIFO, head visible on dout (0 when empty)
// Revision: 1.0
// ------------------------------------------------------------------
module stream_sync_fifo
  import streamif_pkg::*;
#(
  parameter int WIDTH = DEF_TDATA_WIDTH + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra MSB on each pointer separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/axi4_stream_writer.sv
`default_nettype none
// ------------------------------------------------------------------
// axi4_stream_writer: buffered AXI4-Stream master with length-driven TLAST
// Revision: 1.0
// ------------------------------------------------------------------
module axi4_stream_writer
  import streamif_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int C_FIFO_DEPTH         = DEF_FIFO_DEPTH,
  parameter int C_PKT_LEN_WIDTH      = DEF_PKT_LEN_WIDTH
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  input  logic [C_PKT_LEN_WIDTH-1:0]          packet_len,
  input  logic                                data_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     data,
  output logic                                ready,
  output logic                                pkt_done
);

  localparam int STRB_WIDTH = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int FIFO_WIDTH = C_M_AXIS_TDATA_WIDTH + 1;
  localparam logic [STRB_WIDTH-1:0]      TSTRB_ONES = STRB_WIDTH'(strb_ones(C_M_AXIS_TDATA_WIDTH));
  localparam logic [C_PKT_LEN_WIDTH-1:0] CNT_ONE    = 1;

  logic                            push;
  logic                            pop;
  logic                            full;
  logic                            empty;
  logic                            beat_last;
  logic                            head_last;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] head_data;
  logic [FIFO_WIDTH-1:0]           fifo_dout;
  logic [C_PKT_LEN_WIDTH-1:0]      cnt;
  logic [C_PKT_LEN_WIDTH-1:0]      len_q;
  logic [C_PKT_LEN_WIDTH-1:0]      eff_len;

  // Length is taken live on the first beat, then held for the rest of the packet.
  always_comb begin
    eff_len = len_q;
    if (cnt == '0) eff_len = (packet_len == '0) ? CNT_ONE : packet_len;
  end

  assign beat_last = (cnt == eff_len - CNT_ONE);
  assign ready     = !full && !M_AXIS_ARESET;
  assign push      = data_valid && ready;
  assign pop       = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      cnt      <= '0;
      len_q    <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= pop && head_last;
      if (push) begin
        if (cnt == '0) len_q <= eff_len;
        cnt <= beat_last ? '0 : cnt + CNT_ONE;
      end
    end
  end

  stream_sync_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst   (M_AXIS_ARESET),
    .push  (push),
    .pop   (pop),
    .din   ({beat_last, data}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign {head_last, head_data} = fifo_dout;
  assign M_AXIS_TVALID = !empty;
  assign M_AXIS_TDATA  = head_data;
  assign M_AXIS_TLAST  = head_last;
  assign M_AXIS_TSTRB  = TSTRB_ONES;

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_writer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_axi4_stream_writer: randomized scoreboard bench for axi4_stream_writer
// Revision: 1.0
// ------------------------------------------------------------------
module tb_axi4_stream_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tready = 1'b0;
  logic [15:0] plen_in = '0;
  logic        dv = 1'b0;
  logic [31:0] din = '0;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        ready_o;
  logic        done_o;

  int total  = 0;
  int passed = 0;

  // Values sampled at the negedge, and what the next posedge will do.
  logic        s_valid, s_last, s_ready, s_done;
  logic [31:0] s_data;
  logic        hs, pushed;

  // Reference model: expected {last,data} stream in order.
  logic [32:0] exp_q[$];
  int          pos = 0;
  int          cur_len = 1;
  logic        pend = 1'b0;

  always #5 clk = ~clk;

  axi4_stream_writer #(
    .C_M_AXIS_TDATA_WIDTH (32),
    .C_FIFO_DEPTH         (4),
    .C_PKT_LEN_WIDTH      (16)
  ) dut (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESET (rst),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready),
    .packet_len    (plen_in),
    .data_valid    (dv),
    .data          (din),
    .ready         (ready_o),
    .pkt_done      (done_o)
  );

  task automatic cycle(input logic v, input logic [31:0] d, input logic tr, input logic [15:0] pl);
    logic lst;
    @(negedge clk);
    s_valid = tvalid; s_data = tdata; s_last = tlast; s_ready = ready_o; s_done = done_o;
    dv = v; din = d; tready = tr; plen_in = pl;
    hs     = s_valid && tr;
    pushed = v && s_ready && !rst;
    if (pushed) begin
      if (pos == 0) cur_len = (pl == 16'd0) ? 1 : int'(pl);
      pos = pos + 1;
      lst = (pos == cur_len);
      exp_q.push_back({lst, d});
      if (lst) pos = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pos  = 0;
    pend = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    total++; if (s_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", s_ready); else passed++;
    total++; if (s_valid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", s_valid); else passed++;
    total++; if (s_last !== 1'b0 || s_done !== 1'b0) $display("FAIL rst_last_done: got %b/%b want 0/0", s_last, s_done); else passed++;
    total++; if (s_data !== 32'd0) $display("FAIL rst_tdata: got %h want 0", s_data); else passed++;
    total++; if (tstrb !== 4'hF) $display("FAIL tstrb: got %h want f", tstrb); else passed++;
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0);
    total++; if (s_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", s_ready); else passed++;
    total++; if (s_valid !== 1'b0 || s_done !== 1'b0) $display("FAIL rst_release_idle: valid=%b done=%b want 0/0", s_valid, s_done); else passed++;
  endtask

  task automatic test_back_to_back();
    int acc = 0, outs = 0, first = -1, lastc = -1, dones = 0;
    logic [32:0] e;
    for (int cyc = 0; cyc < 40 && !(acc == 8 && exp_q.size() == 0 && !pend); cyc++) begin
      cycle(acc < 8, 32'h10 + acc, 1'b1, 16'd4);
      total++; if (s_done !== pend) $display("FAIL b2b_pkt_done: got %b want %b", s_done, pend); else passed++;
      if (s_done) dones++;
      pend = 1'b0;
      if (pushed) acc++;
      if (hs) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL b2b_order: got %b/%h want none", s_last, s_data);
        else begin
          e = exp_q.pop_front();
          if ({s_last, s_data} !== e) $display("FAIL b2b_order: got %b/%h want %b/%h", s_last, s_data, e[32], e[31:0]);
          else passed++;
          pend = e[32];
        end
        total++; if (s_last !== (s_data == 32'h13 || s_data == 32'h17)) $display("FAIL b2b_tlast: data %h got last %b", s_data, s_last); else passed++;
        if (first < 0) first = cyc;
        lastc = cyc;
        outs++;
      end
    end
    total++; if (outs !== 8 || exp_q.size() != 0) $display("FAIL b2b_count: got %0d beats want 8", outs); else passed++;
    total++; if (lastc - first !== 7) $display("FAIL b2b_rate: got span %0d want 7", lastc - first); else passed++;
    total++; if (dones !== 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else passed++;
  endtask

  task automatic test_backpressure();
    int acc = 0, outs = 0;
    logic [32:0] e;
    for (int cyc = 0; cyc < 60 && !(acc == 6 && exp_q.size() == 0 && !pend); cyc++) begin
      cycle(acc < 6, 32'h10 + acc, cyc >= 8, 16'd3);
      if (cyc == 3) begin
        total++; if (s_ready !== 1'b1) $display("FAIL bp_ready_before_full: got %b want 1", s_ready); else passed++;
      end
      if (cyc == 4) begin
        total++; if (s_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", s_ready); else passed++;
      end
      if (cyc >= 1 && cyc < 8) begin
        total++; if (s_valid !== 1'b1 || s_data !== 32'h10) $display("FAIL bp_stall_head: got %b/%h want 1/10", s_valid, s_data); else passed++;
      end
      total++; if (s_done !== pend) $display("FAIL bp_pkt_done: got %b want %b", s_done, pend); else passed++;
      pend = 1'b0;
      if (pushed) acc++;
      if (hs) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL bp_order: got %b/%h want none", s_last, s_data);
        else begin
          e = exp_q.pop_front();
          if ({s_last, s_data} !== e) $display("FAIL bp_order: got %b/%h want %b/%h", s_last, s_data, e[32], e[31:0]);
          else passed++;
          pend = e[32];
        end
        outs++;
      end
    end
    total++; if (acc !== 6 || outs !== 6) $display("FAIL bp_count: got %0d in %0d out want 6/6", acc, outs); else passed++;
  endtask

  task automatic test_len_edges();
    int lens[14] = '{0, 0, 0, 1, 1, 1, 3, 5, 5, 5, 5, 5, 5, 5};
    int acc = 0, outs = 0;
    logic [32:0] e;
    for (int cyc = 0; cyc < 80 && !(acc == 14 && exp_q.size() == 0 && !pend); cyc++) begin
      cycle(acc < 14, $urandom, 1'b1, 16'(lens[acc < 14 ? acc : 13]));
      total++; if (s_done !== pend) $display("FAIL len_pkt_done: got %b want %b", s_done, pend); else passed++;
      pend = 1'b0;
      if (pushed) acc++;
      if (hs) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL len_order: got %b/%h want none", s_last, s_data);
        else begin
          e = exp_q.pop_front();
          if ({s_last, s_data} !== e) $display("FAIL len_order: got %b/%h want %b/%h", s_last, s_data, e[32], e[31:0]);
          else passed++;
          pend = e[32];
        end
        total++;
        if (s_last !== (outs < 6 || outs == 8 || outs == 13)) $display("FAIL len_tlast: beat %0d got %b", outs, s_last);
        else passed++;
        outs++;
      end
    end
    total++; if (outs !== 14) $display("FAIL len_count: got %0d want 14", outs); else passed++;
  endtask

  task automatic test_random();
    int acc = 0, outs = 0;
    logic [32:0] e, prev;
    logic prev_stall = 1'b0, tr;
    for (int cyc = 0; cyc < 20000 && !(acc == 1000 && exp_q.size() == 0 && !pend); cyc++) begin
      tr = 1'($urandom_range(0, 1));
      cycle((acc < 1000) && ($urandom_range(0, 1) == 1), $urandom, tr, 16'd7);
      if (prev_stall) begin
        total++;
        if (s_valid !== 1'b1 || {s_last, s_data} !== prev) $display("FAIL rnd_stable: got %b %b/%h want 1 %b/%h", s_valid, s_last, s_data, prev[32], prev[31:0]);
        else passed++;
      end
      prev_stall = s_valid && !tr;
      prev = {s_last, s_data};
      total++; if (s_done !== pend) $display("FAIL rnd_pkt_done: got %b want %b", s_done, pend); else passed++;
      pend = 1'b0;
      if (pushed) acc++;
      if (hs) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL rnd_order: got %b/%h want none", s_last, s_data);
        else begin
          e = exp_q.pop_front();
          if ({s_last, s_data} !== e) $display("FAIL rnd_order: got %b/%h want %b/%h", s_last, s_data, e[32], e[31:0]);
          else passed++;
          pend = e[32];
        end
        total++; if (s_last !== ((outs % 7) == 6)) $display("FAIL rnd_tlast: beat %0d got %b", outs, s_last); else passed++;
        outs++;
      end
    end
    total++; if (acc !== 1000 || outs !== 1000) $display("FAIL rnd_count: got %0d in %0d out want 1000/1000", acc, outs); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    int acc = 0, outs = 0, lasts = 0, dones = 0;
    logic [32:0] e;
    cycle(1, 32'hA0, 0, 16'd4);
    cycle(1, 32'hA1, 0, 16'd4);
    cycle(0, 0, 0, 16'd4);
    total++; if (s_valid !== 1'b1 || s_data !== 32'hA0) $display("FAIL mid_buffered: got %b/%h want 1/a0", s_valid, s_data); else passed++;
    rst = 1'b1;
    cycle(0, 0, 0, 16'd4);
    total++; if (s_valid !== 1'b0 || s_ready !== 1'b0) $display("FAIL mid_reset: valid=%b ready=%b want 0/0", s_valid, s_ready); else passed++;
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 40 && !(acc == 4 && exp_q.size() == 0 && !pend); cyc++) begin
      cycle(acc < 4, 32'hB0 + acc, 1'b1, 16'd4);
      total++; if (s_done !== pend) $display("FAIL mid_pkt_done: got %b want %b", s_done, pend); else passed++;
      if (s_done) dones++;
      pend = 1'b0;
      if (pushed) acc++;
      if (hs) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL mid_order: got %b/%h want none", s_last, s_data);
        else begin
          e = exp_q.pop_front();
          if ({s_last, s_data} !== e) $display("FAIL mid_order: got %b/%h want %b/%h", s_last, s_data, e[32], e[31:0]);
          else passed++;
          pend = e[32];
        end
        if (s_last) lasts++;
        outs++;
      end
    end
    total++; if (outs !== 4 || lasts !== 1 || dones !== 1) $display("FAIL mid_packet: got %0d beats %0d last %0d done want 4/1/1", outs, lasts, dones); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_len_edges();
    test_random();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
